imem_loader: RTL and testbench

- Writer side of the instruction memory: accepts a byte stream over a valid/ready handshake and packs every four bytes into one 32-bit word, big-endian.
- Writes each word into the instruction RAM through a single synchronous write port, at sequential addresses from 0.
- Holds the processor in reset while loading and raises done when the requested word count has been written.
- Sits between the board-level download path and the instruction memory that the fetch stage reads.

---
 rtl/imem_loader.sv | 110 +++++++++++
 tb/tb_imem_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words
// and writes them to sequential RAM addresses while holding the CPU in reset.
module imem_loader #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_e;

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q,    state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W:0]   target_q,   target_d;
    logic [23:0]       pack_q,     pack_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            target_q   <= '0;
            pack_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            target_q   <= target_d;
            pack_q     <= pack_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        target_d   = target_q;
        pack_d     = pack_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    target_d   = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    state_d    = (num_words == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (in_valid) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: pack_d[23:16] = in_data;
                        2'd1: pack_d[15:8]  = in_data;
                        2'd2: pack_d[7:0]   = in_data;
                        default: begin
                            // Word and address are captured here so they stay stable after WRITE.
                            wdata_d = {pack_q, in_data};
                            addr_d  = word_cnt_q[ADDR_W-1:0];
                            state_d = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                word_cnt_d = word_cnt_q + 1'b1;
                state_d    = (word_cnt_d < target_q) ? S_COLLECT : S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_COLLECT);
        mem_we    = (state_q == S_WRITE);
        busy      = (state_q == S_COLLECT) || (state_q == S_WRITE);
        cpu_hold  = busy;
        done      = (state_q == S_DONE);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: queue-based word model checked against
// every RAM write, plus directed reset/abort/zero-length/clamp scenarios.
module tb_imem_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   num_words;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          cpu_hold;
    logic          done;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0;
    int unsigned we_cnt = 0;
    int unsigned last_we_cyc = 0;
    int unsigned model_addr = 0;

    logic [7:0]    wbuf[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [31:0]   exp_data_q[$];

    imem_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_words (num_words),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .cpu_hold  (cpu_hold),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: every four accepted bytes form one big-endian word at the next address.
    function automatic void model_accept(input logic [7:0] b);
        wbuf.push_back(b);
        if (wbuf.size() == 4) begin
            exp_addr_q.push_back(AW'(model_addr));
            exp_data_q.push_back({wbuf[0], wbuf[1], wbuf[2], wbuf[3]});
            model_addr++;
            wbuf.delete();
        end
    endfunction

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            we_cnt++;
            last_we_cyc = cyc;
            check("we_ready_low", {63'd0, in_ready}, 64'd0);
            check("we_busy_hold", {62'd0, busy, cpu_hold}, 64'd3);
            if (exp_addr_q.size() == 0) begin
                check("unexpected_we", {63'd0, mem_we}, 64'd0);
            end else begin
                check("wr_addr", {54'd0, mem_addr}, {54'd0, exp_addr_q.pop_front()});
                check("wr_data", {32'd0, mem_wdata}, {32'd0, exp_data_q.pop_front()});
            end
        end
    end

    task automatic check_idle_outs(input string tag);
        check(tag, {17'd0, in_ready, mem_we, busy, cpu_hold, done, mem_addr, mem_wdata}, 64'd0);
    endtask

    task automatic do_start(input int unsigned n);
        start      = 1'b1;
        num_words  = (AW+1)'(n);
        model_addr = 0;
        wbuf.delete();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit toggle, input bit noise);
        int unsigned waitc = 0;
        if (toggle) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        if (noise) begin
            start     = ($urandom_range(0, 3) == 0);
            num_words = (AW+1)'($urandom);
        end
        @(negedge clk);
        while (in_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (in_ready !== 1'b1) begin
            check("ready_timeout", {63'd0, in_ready}, 64'd1);
            in_valid = 1'b0;
            start    = 1'b0;
            return;
        end
        model_accept(b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int unsigned bound, input bit chk_lat);
        int unsigned n = 0;
        while (done !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_busy_off"}, {62'd0, busy, cpu_hold}, 64'd0);
        if (chk_lat) check({tag, "_done_lat"}, 64'(cyc - last_we_cyc), 64'd1);
        check({tag, "_model_empty"}, 64'(exp_addr_q.size() + wbuf.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        logic [7:0] seq [8];
        seq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

        reset = 1'b1; start = 1'b0; num_words = '0; in_data = '0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_idle_outs("reset_idle");
        end
        @(posedge clk); #1;

        // Two words, back-to-back bytes.
        base = we_cnt;
        do_start(2);
        check("t2_busy", {62'd0, busy, cpu_hold}, 64'd3);
        foreach (seq[i]) push_byte(seq[i], 1'b0, 1'b0);
        wait_done("t2", 20, 1'b1);
        check("t2_writes", 64'(we_cnt - base), 64'd2);

        // One word, in_valid toggling; stray byte after DONE must not be taken.
        @(posedge clk); #1;
        base = we_cnt;
        do_start(1);
        for (int i = 0; i < 4; i++) push_byte(8'($urandom), 1'b1, 1'b0);
        wait_done("t3", 20, 1'b1);
        check("t3_writes", 64'(we_cnt - base), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_ready_after_done", {63'd0, in_ready}, 64'd0);
            check("t3_done_sticky", {63'd0, done}, 64'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Zero-length load, then a fresh one-word load from DONE.
        base = we_cnt;
        do_start(0);
        @(negedge clk);
        check("t4_zero_done", {61'd0, done, busy, mem_we}, 64'd4);
        @(posedge clk); #1;
        do_start(1);
        check("t4_done_clear", {62'd0, done, busy}, 64'd1);
        for (int i = 0; i < 4; i++) push_byte(8'($urandom), 1'b0, 1'b0);
        wait_done("t4", 20, 1'b1);
        check("t4_writes", 64'(we_cnt - base), 64'd1);

        // Reset in the middle of a four-word load.
        @(posedge clk); #1;
        base = we_cnt;
        do_start(4);
        for (int i = 0; i < 6; i++) push_byte(8'($urandom), 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        wbuf.delete();
        check("t5_pending", 64'(exp_addr_q.size()), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle_outs("t5_after_reset");
        end
        check("t5_writes", 64'(we_cnt - base), 64'd1);
        @(posedge clk); #1;
        base = we_cnt;
        do_start(1);
        for (int i = 0; i < 4; i++) push_byte(8'($urandom), 1'b0, 1'b0);
        wait_done("t5b", 20, 1'b1);
        check("t5b_writes", 64'(we_cnt - base), 64'd1);

        // Oversized request clamps to full depth; start pulses mid-load are ignored.
        @(posedge clk); #1;
        base = we_cnt;
        do_start(2047);
        for (int i = 0; i < 4096; i++) push_byte(8'($urandom), 1'b0, 1'b1);
        wait_done("t6", 20, 1'b1);
        check("t6_writes", 64'(we_cnt - base), 64'd1024);
        check("t6_last_addr", {54'd0, mem_addr}, 64'd1023);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
